// File: rtl/deskew_bank.sv
// ---------------------------------------------------------------------------
// deskew_bank
//
// Re-aligns a diagonally skewed multi-lane stream leaving a systolic array.
// Lane i of row r arrives i shift steps after lane 0 of the same row, so
// lane i is held back LANES-1-i shift steps. After that delay all lanes of
// a row land in the output register on the same shift edge.
//
// Each lane with a non-zero delay keeps its words in a small circular
// buffer. A per-lane valid bit travels alongside the data. Lanes whose
// delayed valid bit is clear are masked to zero on the output.
//
// Parameters
//   D_W    width of one lane word (signed)
//   LANES  lane count (>= 1)
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset (wins over shift_en)
//   shift_en   advance every lane one step; everything holds when low
//   data_in    skewed input, lane i at [i*D_W +: D_W]
//   valid_in   per-lane valid, skewed like data_in
//   data_out   aligned row (registered); invalid lanes read as zero
//   valid_out  registered: every lane of the aligned row was valid
//   skew_err   sticky flag for a partially valid row
//   err_cnt    saturating count of partially valid rows
//
// Optional feature: define DESKEW_ERR_EN to compile in the misalignment
// checker. Without it, skew_err and err_cnt are tied to zero and the
// datapath is unchanged.
// ---------------------------------------------------------------------------
module deskew_bank #(
  parameter int D_W   = 32,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic [LANES*D_W-1:0] data_in,
  input  logic [LANES-1:0]     valid_in,
  output logic [LANES*D_W-1:0] data_out,
  output logic                 valid_out,
  output logic                 skew_err,
  output logic [15:0]          err_cnt
);

  // Delayed (already aligned) valid bit and word of each lane, before masking.
  logic [LANES-1:0]          dv_s;
  logic [LANES-1:0][D_W-1:0] dword_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DEPTH = LANES - 1 - i;

    if (DEPTH == 0) begin : g_pass
      // The last lane arrives last, so it needs no delay at all.
      assign dv_s[i]    = valid_in[i];
      assign dword_s[i] = data_in[i*D_W +: D_W];
    end else if (DEPTH == 1) begin : g_one
      // A one-entry ring degenerates to a single register. Its pointers are
      // permanently zero, so they are not materialised.
      logic [D_W-1:0] word_q;
      logic           vld_q;

      // Valid bit: cleared by reset so in-flight rows are discarded.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (shift_en) begin
          vld_q <= valid_in[i];
        end
      end

      // Data word: no reset, because it is masked by the valid bit anyway.
      always_ff @(posedge clk) begin
        if (shift_en) begin
          word_q <= data_in[i*D_W +: D_W];
        end
      end

      assign dv_s[i]    = vld_q;
      assign dword_s[i] = word_q;
    end else begin : g_ring
      localparam int PW = $clog2(DEPTH);

      logic [D_W-1:0] mem_q [DEPTH];
      logic [DEPTH-1:0] vld_q;
      logic [PW-1:0]  wr_ptr_q;
      logic [PW-1:0]  wr_ptr_d;
      logic [PW-1:0]  rd_ptr_q;
      logic [PW-1:0]  rd_ptr_d;

      // Both pointers advance once per shift and wrap DEPTH-1 -> 0. They start
      // equal, so the read always returns the entry written DEPTH shifts ago
      // (read-before-write on the shared slot).
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ptr_q == PW'(DEPTH - 1)) begin
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ptr_q == PW'(DEPTH - 1)) begin
          rd_ptr_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end

      // Pointers and stored valid bits: reset so in-flight rows are discarded.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          vld_q    <= '0;
        end else if (shift_en) begin
          vld_q[wr_ptr_q] <= valid_in[i];
          wr_ptr_q        <= wr_ptr_d;
          rd_ptr_q        <= rd_ptr_d;
        end
      end

      // Data storage: a plain write port without reset, so it maps to distributed RAM.
      always_ff @(posedge clk) begin
        if (shift_en) begin
          mem_q[wr_ptr_q] <= data_in[i*D_W +: D_W];
        end
      end

      assign dv_s[i]    = vld_q[rd_ptr_q];
      assign dword_s[i] = mem_q[rd_ptr_q];
    end
  end

  logic [LANES*D_W-1:0] data_out_q;
  logic [LANES*D_W-1:0] data_out_d;
  logic                 valid_out_q;
  logic                 valid_out_d;

  // Mask invalid lanes to zero. The row is valid only when every lane is valid.
  always_comb begin
    data_out_d  = '0;
    valid_out_d = &dv_s;
    for (int l = 0; l < LANES; l++) begin
      if (dv_s[l]) begin
        data_out_d[l*D_W +: D_W] = dword_s[l];
      end else begin
        data_out_d[l*D_W +: D_W] = '0;
      end
    end
  end

  // Output register: loads only on a shift and holds through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else if (shift_en) begin
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

`ifdef DESKEW_ERR_EN
  logic        partial_s;
  logic        skew_err_q;
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  // A row is misaligned when some of its lanes are valid, but not all of them.
  always_comb begin
    partial_s = (|dv_s) && !(&dv_s);
    if (err_cnt_q == 16'hFFFF) begin
      err_cnt_d = err_cnt_q;
    end else begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Sticky error flag and saturating counter, updated on shift edges only.
  always_ff @(posedge clk) begin
    if (rst) begin
      skew_err_q <= 1'b0;
      err_cnt_q  <= 16'h0000;
    end else if (shift_en && partial_s) begin
      skew_err_q <= 1'b1;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign skew_err = skew_err_q;
  assign err_cnt  = err_cnt_q;
`else
  assign skew_err = 1'b0;
  assign err_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_deskew_bank.sv
// Self-checking bench for deskew_bank. The main instance uses LANES=4, D_W=32.
// Two small extra instances cover LANES=1 and LANES=2.
// The reference model keeps the last LANES shift inputs in a history array.
// Lane i of the output is taken from the input applied LANES-1-i shifts ago.
module tb_deskew_bank;
  localparam int D_W   = 32;
  localparam int LANES = 4;
  localparam int VW    = LANES * D_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            shift_en;
  logic [VW-1:0]   data_in;
  logic [LANES-1:0] valid_in;
  logic [VW-1:0]   data_out;
  logic            valid_out;
  logic            skew_err;
  logic [15:0]     err_cnt;

  logic        se1, vi1, vo1, er1;
  logic [31:0] di1, do1;
  logic [15:0] ec1;
  logic        se2, vo2, er2;
  logic [1:0]  vi2;
  logic [63:0] di2, do2;
  logic [15:0] ec2;

  deskew_bank #(.D_W(D_W), .LANES(LANES)) u_dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .skew_err(skew_err), .err_cnt(err_cnt));

  deskew_bank #(.D_W(32), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .shift_en(se1), .data_in(di1), .valid_in(vi1),
    .data_out(do1), .valid_out(vo1), .skew_err(er1), .err_cnt(ec1));

  deskew_bank #(.D_W(32), .LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .shift_en(se2), .data_in(di2), .valid_in(vi2),
    .data_out(do2), .valid_out(vo2), .skew_err(er2), .err_cnt(ec2));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [LANES-1:0] hv [LANES];
  logic [VW-1:0]    hd [LANES];
  logic [VW-1:0]    exp_data;
  logic             exp_valid;
  logic             exp_err;
  logic [15:0]      exp_cnt;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] row_word(input int r);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*D_W +: D_W] = 32'(r * 16 + i + 1);
    return v;
  endfunction

  // Update the model from the inputs applied at this edge.
  task automatic model_edge(input logic sh, input logic [VW-1:0] din,
                            input logic [LANES-1:0] vin, input logic r);
    logic [LANES-1:0] dv;
    if (r) begin
      for (int k = 0; k < LANES; k++) hv[k] = '0;
      exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = 16'd0;
    end else if (sh) begin
      for (int k = LANES - 1; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      hv[0] = vin;
      hd[0] = din;
      for (int i = 0; i < LANES; i++) begin
        dv[i] = hv[LANES-1-i][i];
        exp_data[i*D_W +: D_W] = dv[i] ? hd[LANES-1-i][i*D_W +: D_W] : 32'd0;
      end
      exp_valid = &dv;
      if (|dv && !(&dv)) begin
        exp_err = 1'b1;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  endtask

  task automatic step(input logic sh, input logic [VW-1:0] din, input logic [LANES-1:0] vin,
                      input logic r, input string tag);
    logic        e_err;
    logic [15:0] e_cnt;
    shift_en = sh; data_in = din; valid_in = vin; rst = r;
    @(posedge clk);
    model_edge(sh, din, vin, r);
    #1;
`ifdef DESKEW_ERR_EN
    e_err = exp_err; e_cnt = exp_cnt;
`else
    e_err = 1'b0; e_cnt = 16'd0;
`endif
    check_val({tag, "/data"}, data_out, exp_data);
    check_val({tag, "/valid"}, valid_out, exp_valid);
    check_val({tag, "/skew_err"}, skew_err, e_err);
    check_val({tag, "/err_cnt"}, err_cnt, e_cnt);
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*D_W +: D_W] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VW-1:0]    din;
    logic [LANES-1:0] vin;
    logic [VW-1:0]    row_exp;
    logic [63:0]      exp2;
    logic [31:0]      neg5;
    int s, next_row, iters;
    logic sh;

    for (int k = 0; k < LANES; k++) begin hv[k] = '0; hd[k] = '0; end
    exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = 16'd0;
    se1 = 1'b0; di1 = '0; vi1 = 1'b0; se2 = 1'b0; di2 = '0; vi2 = '0;

    // Reset: two cycles with shift_en high.
    step(1'b1, rnd_vec(), 4'hF, 1'b1, "reset0");
    step(1'b1, rnd_vec(), 4'hF, 1'b1, "reset1");
    check_val("reset_zero", {valid_out, data_out}, '0);

    // Aligned row 10..13, lane i valid only at shift i.
    for (int k = 0; k < LANES; k++) begin
      din = '0;
      din[k*D_W +: D_W] = 32'(10 + k);
      step(1'b1, din, 4'(1 << k), 1'b0, "aligned");
    end
    check_val("aligned_row", data_out, {32'd13, 32'd12, 32'd11, 32'd10});
    check_val("aligned_valid", valid_out, 1'b1);
    step(1'b1, '0, '0, 1'b0, "aligned_tail");

    // Back-to-back stream of 32 rows with random stalls.
    s = 0; next_row = 0; iters = 0;
    while (s < 32 + LANES - 1 && iters < 2000) begin
      iters++;
      sh = 1'($urandom_range(0, 1));
      if (sh) begin
        din = '0; vin = '0;
        for (int i = 0; i < LANES; i++) begin
          if (s - i >= 0 && s - i < 32) begin
            row_exp = row_word(s - i);
            din[i*D_W +: D_W] = row_exp[i*D_W +: D_W];
            vin[i] = 1'b1;
          end
        end
        s++;
        step(1'b1, din, vin, 1'b0, "stream");
        if (valid_out) begin
          check_val("stream_order", data_out, row_word(next_row));
          next_row++;
        end
      end else begin
        step(1'b0, rnd_vec(), 4'($urandom_range(0, 15)), 1'b0, "stall");
      end
    end
    check_val("stream_rows", 32'(next_row), 32'd32);

    // Mid-stream reset after two lanes of a row.
    step(1'b1, {96'd0, 32'd50}, 4'b0001, 1'b0, "mid_a");
    step(1'b1, {64'd0, 32'd51, 32'd0}, 4'b0010, 1'b0, "mid_b");
    step(1'b1, '0, '0, 1'b1, "mid_rst");
    for (int k = 0; k < LANES; k++) step(1'b1, '0, '0, 1'b0, "mid_drain");
    check_val("mid_discard", {valid_out, data_out}, '0);
    for (int k = 0; k < LANES; k++) begin
      din = '0;
      din[k*D_W +: D_W] = 32'(60 + k);
      step(1'b1, din, 4'(1 << k), 1'b0, "mid_row");
    end
    check_val("mid_next_row", data_out, {32'd63, 32'd62, 32'd61, 32'd60});
    check_val("mid_next_valid", valid_out, 1'b1);

    // Misalignment: lane 2 valid one shift late.
    step(1'b0, '0, '0, 1'b1, "mis_rst");
    step(1'b1, {96'd0, 32'd20}, 4'b0001, 1'b0, "mis0");
    step(1'b1, {64'd0, 32'd21, 32'd0}, 4'b0010, 1'b0, "mis1");
    step(1'b1, '0, 4'b0000, 1'b0, "mis2");
    step(1'b1, {32'd23, 32'd22, 64'd0}, 4'b1100, 1'b0, "mis3");
    step(1'b1, '0, '0, 1'b0, "mis4");
    step(1'b1, '0, '0, 1'b0, "mis5");
`ifdef DESKEW_ERR_EN
    check_val("mis_err", skew_err, 1'b1);
    check_val("mis_cnt", err_cnt, 16'd2);
`else
    check_val("mis_err", skew_err, 1'b0);
    check_val("mis_cnt", err_cnt, 16'd0);
`endif

    // LANES=1: output is the masked input one shift later.
    for (int k = 0; k < 8; k++) begin
      se1 = 1'b1; di1 = $urandom; vi1 = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_val("l1_data", do1, vi1 ? di1 : 32'd0);
      check_val("l1_valid", vo1, vi1);
    end
    row_exp = '0;
    row_exp[32:0] = {vo1, do1};
    se1 = 1'b0; di1 = $urandom; vi1 = ~vi1;
    @(posedge clk); #1;
    check_val("l1_hold", {vo1, do1}, row_exp[32:0]);
    check_val("l1_noerr", {er1, ec1}, 17'd0);
    se1 = 1'b0;

    // LANES=2: row {-5,7}; lane 0 goes through a one-entry buffer.
    neg5 = -32'sd5;
    se2 = 1'b1; di2 = {32'd0, 32'd7}; vi2 = 2'b01;
    @(posedge clk); #1;
    check_val("l2_first_valid", vo2, 1'b0);
    di2 = {neg5, 32'd0}; vi2 = 2'b10;
    @(posedge clk); #1;
    exp2 = {neg5, 32'd7};
    check_val("l2_row", do2, exp2);
    check_val("l2_valid", vo2, 1'b1);
    se2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
